// File: rtl/lif_neuron_array.sv
// Array of leaky integrate-and-fire neurons with a selectable membrane-voltage tap
// and a saturating total-spike counter.

module lif_lane #(
   parameter int W_IN       = 8,
   parameter int W_MEM      = 8,
   parameter int LEAK_SHIFT = 3,
   parameter int REFRAC     = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [W_IN-1:0]  i_syn,
   input  logic [W_MEM-1:0] threshold,
   output logic [W_MEM-1:0] v,
   output logic             spike,
   output logic             fire
);
   logic [3:0]       r;
   logic [W_MEM-1:0] v_leak;
   logic [W_MEM:0]   v_sum;
   logic [W_MEM-1:0] v_next;

   // One extra bit catches the carry so the sum can clamp instead of wrapping.
   always_comb begin
      v_leak = v - (v >> LEAK_SHIFT);
      v_sum  = {1'b0, v_leak} + (W_MEM+1)'(i_syn);
      v_next = v_sum[W_MEM] ? '1 : v_sum[W_MEM-1:0];
      fire   = (r == '0) && (v_next >= threshold);
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         v     <= '0;
         r     <= '0;
         spike <= 1'b0;
      end else if (!en) begin
         spike <= 1'b0;
      end else if (r != '0) begin
         r     <= r - 4'd1;
         v     <= '0;
         spike <= 1'b0;
      end else if (fire) begin
         spike <= 1'b1;
         v     <= '0;
         r     <= 4'(REFRAC);
      end else begin
         v     <= v_next;
         spike <= 1'b0;
      end
   end
endmodule

module lif_neuron_array #(
   parameter int N_CH       = 4,
   parameter int W_IN       = 8,
   parameter int W_MEM      = 8,
   parameter int LEAK_SHIFT = 3,
   parameter int REFRAC     = 4,
   parameter int W_SEL      = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic [N_CH*W_IN-1:0] I_syn,
   input  logic [W_MEM-1:0]     threshold,
   input  logic [W_SEL-1:0]     sel,
   output logic [W_MEM-1:0]     V_mem,
   output logic [N_CH-1:0]      spike,
   output logic [7:0]           spike_count
);
   logic [N_CH-1:0][W_MEM-1:0] v;
   logic [N_CH-1:0]            fire;
   logic [3:0]                 n_fire;
   logic [8:0]                 count_sum;

   for (genvar g = 0; g < N_CH; g++) begin : g_lane
      lif_lane #(
         .W_IN(W_IN), .W_MEM(W_MEM), .LEAK_SHIFT(LEAK_SHIFT), .REFRAC(REFRAC)
      ) u_lane (
         .clk(clk), .rst_n(rst_n), .en(en),
         .i_syn(I_syn[g*W_IN +: W_IN]), .threshold(threshold),
         .v(v[g]), .spike(spike[g]), .fire(fire[g])
      );
   end

   // Out-of-range selects fall through to zero.
   always_comb begin
      V_mem = '0;
      for (int k = 0; k < N_CH; k++)
         if (sel == W_SEL'(k)) V_mem = v[k];
   end

   always_comb begin
      n_fire = '0;
      for (int k = 0; k < N_CH; k++) n_fire = n_fire + 4'(fire[k]);
      count_sum = {1'b0, spike_count} + 9'(n_fire);
   end

   always_ff @(posedge clk) begin
      if (rst_n)
         spike_count <= '0;
      else if (en)
         spike_count <= count_sum[8] ? 8'hff : count_sum[7:0];
   end
endmodule
